// File: rtl/axil_reg_pkg.sv
// axil_reg_pkg: shared response codes, FSM encodings and sizing helper for the AXI-Lite register bank.
package axil_reg_pkg;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [0:0] W_IDLE = 1'b0;
    localparam logic [0:0] W_RESP = 1'b1;
    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_RESP = 1'b1;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/axil_reg_decode.sv
// axil_reg_decode: maps a word address onto {hit, is_ro, index} within the register window.
module axil_reg_decode
    import axil_reg_pkg::*;
#(
    parameter int          AXIL_AW   = 16,
    parameter int          NUM_RW    = 8,
    parameter int          NUM_RO    = 8,
    parameter logic [31:0] ADDR_BASE = 32'h0,
    parameter int          IW        = idx_w(NUM_RW + NUM_RO)
) (
    input  logic [29:0]   word_addr,
    output logic          hit,
    output logic          is_ro,
    output logic [IW-1:0] idx
);
    logic [AXIL_AW-3:0] word;
    logic [31:0]        word32;

    // Byte-offset bits were dropped by the caller; only the word offset matters here.
    assign word   = word_addr[AXIL_AW-3:0] - ADDR_BASE[AXIL_AW-1:2];
    assign word32 = 32'(word);
    assign hit    = (word_addr[29:AXIL_AW-2] == ADDR_BASE[31:AXIL_AW]) && (word32 < 32'(NUM_RW + NUM_RO));
    assign is_ro  = word32 >= 32'(NUM_RW);
    assign idx    = IW'(word);
endmodule

// File: rtl/axil_reg_slave.sv
// axil_reg_slave: AXI4-Lite register bank with NUM_RW control registers and NUM_RO status words.
module axil_reg_slave
    import axil_reg_pkg::*;
#(
    parameter int                   AXIL_AW   = 16,
    parameter int                   NUM_RW    = 8,
    parameter int                   NUM_RO    = 8,
    parameter logic [31:0]          ADDR_BASE = 32'h0,
    parameter logic [32*NUM_RW-1:0] RW_RESET  = '0
) (
    input  logic                   aclk,
    input  logic                   rst,
    input  logic                   s_axil_awvalid,
    output logic                   s_axil_awready,
    input  logic [31:0]            s_axil_awaddr,
    input  logic [2:0]             s_axil_awprot,
    input  logic                   s_axil_wvalid,
    output logic                   s_axil_wready,
    input  logic [31:0]            s_axil_wdata,
    input  logic [3:0]             s_axil_wstrb,
    output logic                   s_axil_bvalid,
    input  logic                   s_axil_bready,
    output logic [1:0]             s_axil_bresp,
    input  logic                   s_axil_arvalid,
    output logic                   s_axil_arready,
    input  logic [31:0]            s_axil_araddr,
    input  logic [2:0]             s_axil_arprot,
    output logic                   s_axil_rvalid,
    input  logic                   s_axil_rready,
    output logic [31:0]            s_axil_rdata,
    output logic [1:0]             s_axil_rresp,
    output logic [32*NUM_RW-1:0]   ctrl_regs,
    output logic [NUM_RW-1:0]      ctrl_wr_pulse,
    input  logic [32*NUM_RO-1:0]   status_in
);
    localparam int IW = idx_w(NUM_RW + NUM_RO);

    logic [0:0]              wstate_q, wstate_d, rstate_q, rstate_d;
    logic                    aw_got_q, aw_got_d, w_got_q, w_got_d;
    logic                    awready_q, awready_d, wready_q, wready_d, arready_q, arready_d;
    logic [29:0]             awaddr_q, awaddr_d;
    logic [31:0]             wdata_q, wdata_d, rdata_q, rdata_d;
    logic [3:0]              wstrb_q, wstrb_d;
    logic                    bvalid_q, bvalid_d, rvalid_q, rvalid_d;
    logic [1:0]              bresp_q, bresp_d, rresp_q, rresp_d;
    logic [NUM_RW-1:0][31:0] ctrl_q, ctrl_d;
    logic [NUM_RW-1:0]       pulse_q, pulse_d;

    logic                    aw_hs, w_hs, ar_hs, commit;
    logic [29:0]             eff_wa;
    logic [31:0]             eff_data;
    logic [3:0]              eff_strb;
    logic                    w_hit, w_ro, r_hit, r_ro;
    logic [IW-1:0]           w_idx, r_idx;

    assign aw_hs    = s_axil_awvalid && awready_q;
    assign w_hs     = s_axil_wvalid && wready_q;
    assign ar_hs    = s_axil_arvalid && arready_q;
    assign eff_wa   = aw_hs ? s_axil_awaddr[31:2] : awaddr_q;
    assign eff_data = w_hs ? s_axil_wdata : wdata_q;
    assign eff_strb = w_hs ? s_axil_wstrb : wstrb_q;
    // A same-cycle AW+W commits on its handshake edge; split arrivals commit once both are held.
    assign commit   = (wstate_q == W_IDLE) && ((aw_got_q && w_got_q) || (aw_hs && w_hs));

    axil_reg_decode #(.AXIL_AW(AXIL_AW), .NUM_RW(NUM_RW), .NUM_RO(NUM_RO), .ADDR_BASE(ADDR_BASE), .IW(IW)) u_wdec (
        .word_addr(eff_wa), .hit(w_hit), .is_ro(w_ro), .idx(w_idx)
    );
    axil_reg_decode #(.AXIL_AW(AXIL_AW), .NUM_RW(NUM_RW), .NUM_RO(NUM_RO), .ADDR_BASE(ADDR_BASE), .IW(IW)) u_rdec (
        .word_addr(s_axil_araddr[31:2]), .hit(r_hit), .is_ro(r_ro), .idx(r_idx)
    );

    always_comb begin
        wstate_d = wstate_q;
        aw_got_d = aw_got_q || aw_hs;
        w_got_d  = w_got_q || w_hs;
        awaddr_d = eff_wa;
        wdata_d  = eff_data;
        wstrb_d  = eff_strb;
        bvalid_d = bvalid_q && !s_axil_bready;
        bresp_d  = bresp_q;
        ctrl_d   = ctrl_q;
        pulse_d  = '0;
        if (commit) begin
            wstate_d = W_RESP;
            aw_got_d = 1'b0;
            w_got_d  = 1'b0;
            bvalid_d = 1'b1;
            bresp_d  = !w_hit ? RESP_DECERR : w_ro ? RESP_SLVERR : RESP_OKAY;
            for (int i = 0; i < NUM_RW; i++) begin
                if (w_hit && !w_ro && 32'(w_idx) == i) begin
                    pulse_d[i] = 1'b1;
                    for (int b = 0; b < 4; b++)
                        if (eff_strb[b]) ctrl_d[i][8*b+:8] = eff_data[8*b+:8];
                end
            end
        end else if (wstate_q == W_RESP && s_axil_bready) begin
            wstate_d = W_IDLE;
        end
        awready_d = (wstate_d == W_IDLE) && !aw_got_d;
        wready_d  = (wstate_d == W_IDLE) && !w_got_d;
    end

    // Reads sample ctrl_q, so a commit on the same edge is not yet visible.
    always_comb begin
        rstate_d = rstate_q;
        rvalid_d = rvalid_q && !s_axil_rready;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        if (ar_hs) begin
            rstate_d = R_RESP;
            rvalid_d = 1'b1;
            rdata_d  = '0;
            rresp_d  = r_hit ? RESP_OKAY : RESP_DECERR;
            for (int i = 0; i < NUM_RW; i++)
                if (r_hit && !r_ro && 32'(r_idx) == i) rdata_d = ctrl_q[i];
            for (int j = 0; j < NUM_RO; j++)
                if (r_hit && r_ro && 32'(r_idx) == NUM_RW + j) rdata_d = status_in[32*j+:32];
        end else if (rstate_q == R_RESP && s_axil_rready) begin
            rstate_d = R_IDLE;
        end
        arready_d = rstate_d == R_IDLE;
    end

    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            wstate_q  <= W_IDLE;
            rstate_q  <= R_IDLE;
            aw_got_q  <= 1'b0;
            w_got_q   <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            arready_q <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= '0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= '0;
            ctrl_q    <= RW_RESET;
            pulse_q   <= '0;
        end else begin
            wstate_q  <= wstate_d;
            rstate_q  <= rstate_d;
            aw_got_q  <= aw_got_d;
            w_got_q   <= w_got_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            arready_q <= arready_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            ctrl_q    <= ctrl_d;
            pulse_q   <= pulse_d;
        end
    end

    assign s_axil_awready = awready_q;
    assign s_axil_wready  = wready_q;
    assign s_axil_bvalid  = bvalid_q;
    assign s_axil_bresp   = bresp_q;
    assign s_axil_arready = arready_q;
    assign s_axil_rvalid  = rvalid_q;
    assign s_axil_rdata   = rdata_q;
    assign s_axil_rresp   = rresp_q;
    assign ctrl_regs      = ctrl_q;
    assign ctrl_wr_pulse  = pulse_q;
endmodule
